vending_machine: RTL and testbench

Four-drink vending controller, one clock domain. Accepts one coin per clock, accumulates credit, shows which drinks are affordable, and on a valid selection dispenses one drink and returns change. Sits between the coin acceptor/selection panel and the dispenser/change-hopper drivers. Outputs follow the four inputs in port order, so a four-input positional hookup stays legal.

---
 rtl/vending_pkg.sv | 31 +++
 rtl/vending_price_lut.sv | 37 +++
 rtl/vending_machine.sv | 98 +++++++++
 tb/tb_vending_machine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared constants for the four-drink vending controller: drink codes,
// legal coin values, FSM state encodings and default prices.
package vending_pkg;

    // Drink selection codes as presented on drink_choose / drink_out.
    localparam logic [2:0] DRINK_NONE   = 3'd0;
    localparam logic [2:0] DRINK_TEA    = 3'd1;
    localparam logic [2:0] DRINK_COKE   = 3'd2;
    localparam logic [2:0] DRINK_COFFEE = 3'd3;
    localparam logic [2:0] DRINK_MILK   = 3'd4;

    // Coin values the acceptor may present; everything else is rejected.
    localparam logic [5:0] COIN_1  = 6'd1;
    localparam logic [5:0] COIN_5  = 6'd5;
    localparam logic [5:0] COIN_10 = 6'd10;
    localparam logic [5:0] COIN_50 = 6'd50;

    // Controller states, kept as plain constants for legacy tooling.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CREDIT = 2'd1;
    localparam state_t ST_VEND   = 2'd2;

    // Default price list and credit ceiling.
    localparam logic [7:0] DEF_PRICE_TEA    = 8'd10;
    localparam logic [7:0] DEF_PRICE_COKE   = 8'd15;
    localparam logic [7:0] DEF_PRICE_COFFEE = 8'd25;
    localparam logic [7:0] DEF_PRICE_MILK   = 8'd20;
    localparam logic [7:0] DEF_CREDIT_MAX   = 8'd99;

endpackage

// File: rtl/vending_price_lut.sv
// Drink code -> price lookup plus the affordable-drink mask derived from
// the credit register. Purely combinational.
module vending_price_lut
    import vending_pkg::*;
#(
    parameter logic [7:0] PRICE_TEA    = DEF_PRICE_TEA,
    parameter logic [7:0] PRICE_COKE   = DEF_PRICE_COKE,
    parameter logic [7:0] PRICE_COFFEE = DEF_PRICE_COFFEE,
    parameter logic [7:0] PRICE_MILK   = DEF_PRICE_MILK
) (
    input  logic [2:0] drink,
    input  logic [7:0] credit,
    output logic [7:0] price,
    output logic       valid,
    output logic [3:0] avail
);

    // Map the selection to its price; unknown or out-of-range codes are invalid.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        price = 8'd0;
        valid = 1'b0;
        case (drink)
            DRINK_TEA:    begin price = PRICE_TEA;    valid = 1'b1; end
            DRINK_COKE:   begin price = PRICE_COKE;   valid = 1'b1; end
            DRINK_COFFEE: begin price = PRICE_COFFEE; valid = 1'b1; end
            DRINK_MILK:   begin price = PRICE_MILK;   valid = 1'b1; end
            default:      begin price = 8'd0;         valid = 1'b0; end
        endcase
    end

    assign avail = {credit >= PRICE_MILK,
                    credit >= PRICE_COFFEE,
                    credit >= PRICE_COKE,
                    credit >= PRICE_TEA};

endmodule

// File: rtl/vending_machine.sv
// Vending controller top: coin validation, credit register, purchase FSM
// and registered dispenser / change-hopper outputs.
module vending_machine
    import vending_pkg::*;
#(
    parameter logic [7:0] PRICE_TEA    = DEF_PRICE_TEA,
    parameter logic [7:0] PRICE_COKE   = DEF_PRICE_COKE,
    parameter logic [7:0] PRICE_COFFEE = DEF_PRICE_COFFEE,
    parameter logic [7:0] PRICE_MILK   = DEF_PRICE_MILK,
    parameter logic [7:0] CREDIT_MAX   = DEF_CREDIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] coin,
    input  logic [2:0] drink_choose,
    output logic [7:0] credit,
    output logic [3:0] avail,
    output logic       dispense,
    output logic [2:0] drink_out,
    output logic [7:0] change,
    output logic       coin_reject
);

    state_t     state;
    logic [7:0] sel_price;
    logic       sel_valid;
    logic       coin_present;
    logic       coin_legal;
    logic       coin_accept;
    logic [7:0] coin_sum;
    logic [7:0] coin_add;
    logic       buy;

    vending_price_lut #(
        .PRICE_TEA    (PRICE_TEA),
        .PRICE_COKE   (PRICE_COKE),
        .PRICE_COFFEE (PRICE_COFFEE),
        .PRICE_MILK   (PRICE_MILK)
    ) u_price_lut (
        .drink  (drink_choose),
        .credit (credit),
        .price  (sel_price),
        .valid  (sel_valid),
        .avail  (avail)
    );

    // Classify the coin; X/Z matches no case item and lands in the reject branch.
    always_comb begin
        coin_present = 1'b1;
        coin_legal   = 1'b0;
        case (coin)
            6'd0:                              coin_present = 1'b0;
            COIN_1, COIN_5, COIN_10, COIN_50:  coin_legal   = 1'b1;
            default:                           coin_legal   = 1'b0;
        endcase
    end

    // Accept a legal coin only if credit stays within the ceiling; a purchase
    // needs a valid, affordable selection against the registered credit.
    assign coin_sum    = credit + {2'b00, coin};
    assign coin_accept = coin_legal && (coin_sum <= CREDIT_MAX);
    assign coin_add    = coin_accept ? {2'b00, coin} : 8'd0;
    assign buy         = (state == ST_CREDIT) && sel_valid && (credit >= sel_price);

    // FSM, credit register and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all registered state.
            state       <= ST_IDLE;
            credit      <= 8'd0;
            dispense    <= 1'b0;
            drink_out   <= DRINK_NONE;
            change      <= 8'd0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_present && !coin_accept;
            if (buy) begin
                state     <= ST_VEND;
                credit    <= 8'd0;
                dispense  <= 1'b1;
                drink_out <= drink_choose;
                change    <= credit + coin_add - sel_price;
            end else begin
                dispense  <= 1'b0;
                drink_out <= DRINK_NONE;
                change    <= 8'd0;
                credit    <= credit + coin_add;
                case (state)
                    ST_IDLE:   state <= coin_accept ? ST_CREDIT : ST_IDLE;
                    ST_CREDIT: state <= ST_CREDIT;
                    ST_VEND:   state <= coin_accept ? ST_CREDIT : ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine with default prices.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] coin;
    logic [2:0] drink_choose;
    logic [7:0] credit;
    logic [3:0] avail;
    logic       dispense;
    logic [2:0] drink_out;
    logic [7:0] change;
    logic       coin_reject;

    int n_checks = 0;
    int n_errors = 0;

    vending_machine dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .drink_choose (drink_choose),
        .credit       (credit),
        .avail        (avail),
        .dispense     (dispense),
        .drink_out    (drink_out),
        .change       (change),
        .coin_reject  (coin_reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [5:0] c);
        coin = c;
        tick();
        coin = 6'd0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".credit"},   credit,      0);
        check({tag, ".avail"},    avail,       0);
        check({tag, ".dispense"}, dispense,    0);
        check({tag, ".drink"},    drink_out,   0);
        check({tag, ".change"},   change,      0);
        check({tag, ".reject"},   coin_reject, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        coin = 6'd0;
        drink_choose = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        check_idle_outputs("reset");

        // Coin accumulation and affordability mask.
        put_coin(6'd10);
        check("c10.credit", credit, 10); check("c10.avail", avail, 4'b0001); check("c10.rej", coin_reject, 0);
        put_coin(6'd5);
        check("c5.credit", credit, 15);  check("c5.avail", avail, 4'b0011);  check("c5.rej", coin_reject, 0);
        put_coin(6'd1);
        check("c1.credit", credit, 16);  check("c1.avail", avail, 4'b0011);  check("c1.rej", coin_reject, 0);
        put_coin(6'd10);
        check("c10b.credit", credit, 26); check("c10b.avail", avail, 4'b1111); check("c10b.rej", coin_reject, 0);

        // Coffee purchase with change.
        drink_choose = 3'd3;
        tick();
        drink_choose = 3'd0;
        check("coffee.disp", dispense, 1); check("coffee.drink", drink_out, 3);
        check("coffee.change", change, 1); check("coffee.credit", credit, 0);
        tick();
        check_idle_outputs("after_coffee");

        // Unaffordable coke ignored, then bought once credit reaches 15.
        put_coin(6'd10);
        drink_choose = 3'd2;
        tick();
        check("coke_low.disp", dispense, 0); check("coke_low.credit", credit, 10);
        put_coin(6'd5);
        check("coke_coin.disp", dispense, 0); check("coke_coin.credit", credit, 15);
        tick();
        check("coke.disp", dispense, 1); check("coke.drink", drink_out, 2);
        check("coke.change", change, 0); check("coke.credit", credit, 0);
        tick();
        check("coke_hold.disp", dispense, 0); check("coke_hold.credit", credit, 0);
        drink_choose = 3'd0;

        // Illegal coins and credit ceiling.
        put_coin(6'd7);
        check("c7.rej", coin_reject, 1); check("c7.credit", credit, 0);
        tick();
        check("c7.rej_clear", coin_reject, 0);
        put_coin(6'b10xxxx);
        check("cx.rej", coin_reject, 1); check("cx.credit", credit, 0);
        put_coin(6'd50);
        check("c50.rej", coin_reject, 0); check("c50.credit", credit, 50);
        put_coin(6'd50);
        check("c50b.rej", coin_reject, 1); check("c50b.credit", credit, 50);
        check("c50b.avail", avail, 4'b1111);

        // Coin arriving during the vend cycle becomes new credit.
        drink_choose = 3'd1;
        tick();
        drink_choose = 3'd0;
        check("tea.disp", dispense, 1); check("tea.change", change, 40); check("tea.credit", credit, 0);
        put_coin(6'd5);
        check("vendcoin.disp", dispense, 0); check("vendcoin.credit", credit, 5);
        check("vendcoin.avail", avail, 4'b0000);

        // Milk purchase with a simultaneous coin.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2.credit", credit, 0);
        put_coin(6'd10);
        put_coin(6'd10);
        check("milk_pre.credit", credit, 20);
        drink_choose = 3'd4;
        coin = 6'd10;
        tick();
        drink_choose = 3'd0;
        coin = 6'd0;
        check("milk.disp", dispense, 1); check("milk.drink", drink_out, 4);
        check("milk.change", change, 10); check("milk.credit", credit, 0);
        check("milk.rej", coin_reject, 0);
        tick();
        check_idle_outputs("after_milk");

        // Reset wins over a simultaneous affordable selection.
        put_coin(6'd10);
        put_coin(6'd10);
        put_coin(6'd5);
        put_coin(6'd1);
        check("pre_rst.credit", credit, 26);
        reset = 1'b1;
        drink_choose = 3'd1;
        tick();
        reset = 1'b0;
        drink_choose = 3'd0;
        check_idle_outputs("rst_sel");
        tick();
        check("rst_sel_after.disp", dispense, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
